// File: rtl/reg_scoreboard.sv
// reg_scoreboard: register scoreboard and operand forwarding for an in-order pipeline.
// Tracks the destination register of each in-flight stage (entry 0 = execute,
// entry DEPTH-1 = writeback). It resolves source operands from the youngest
// producer, or from the register file, and stalls issue while a producer's
// result does not yet exist.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   advance, flush            pipeline move / kill youngest FLUSH_DEPTH entries
//   issue_valid/rd/lat        instruction presented by decode
//   stage_value               per-stage result values, slice k = entry k
//   rs_en/rs_addr/rf_data     per-port lookup request and register-file data
//   rs_data/rs_fwd            resolved operand and forwarded flag per port
//   stall, issue_accept       hazard stall / issue entering entry 0
//   stall_count               saturating count of stall cycles
module reg_scoreboard #(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 3,
  parameter int unsigned READ_PORTS  = 2,
  parameter int unsigned FLUSH_DEPTH = 1,
  parameter int unsigned LAT_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         advance,
  input  logic                         flush,
  input  logic                         issue_valid,
  input  logic [ADDR_W-1:0]            issue_rd,
  input  logic [LAT_W-1:0]             issue_lat,
  input  logic [DEPTH*DATA_W-1:0]      stage_value,
  input  logic [READ_PORTS-1:0]        rs_en,
  input  logic [READ_PORTS*ADDR_W-1:0] rs_addr,
  input  logic [READ_PORTS*DATA_W-1:0] rf_data,
  output logic [READ_PORTS*DATA_W-1:0] rs_data,
  output logic [READ_PORTS-1:0]        rs_fwd,
  output logic                         stall,
  output logic                         issue_accept,
  output logic [15:0]                  stall_count
);

  logic [DEPTH-1:0]             live_q, live_d;
  logic [DEPTH-1:0][ADDR_W-1:0] rd_q, rd_d;
  logic [DEPTH-1:0][LAT_W-1:0]  lat_q, lat_d;
  logic [15:0]                  stall_count_q, stall_count_d;

  // Lookups see an empty scoreboard while reset is asserted.
  logic [DEPTH-1:0]  live_eff;
  logic              hit, hit_rdy;
  logic [DATA_W-1:0] hit_val;
  logic              stall_c;

  assign live_eff = live_q & ~{DEPTH{rst}};

  always_comb begin
    rs_data = rf_data;
    rs_fwd  = '0;
    stall_c = 1'b0;
    hit     = 1'b0;
    hit_rdy = 1'b0;
    hit_val = '0;
    for (int p = 0; p < int'(READ_PORTS); p++) begin
      hit     = 1'b0;
      hit_rdy = 1'b0;
      hit_val = '0;
      // Scan oldest to youngest so the lowest-index (youngest) match wins.
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        if (live_eff[k] && (rd_q[k] == rs_addr[p*ADDR_W +: ADDR_W])) begin
          hit     = 1'b1;
          // A latency beyond the last entry can never satisfy k >= lat.
          hit_rdy = (k >= int'(lat_q[k]));
          hit_val = stage_value[k*DATA_W +: DATA_W];
        end
      end
      if (rs_en[p] && (rs_addr[p*ADDR_W +: ADDR_W] != '0) && hit) begin
        if (hit_rdy) begin
          rs_data[p*DATA_W +: DATA_W] = hit_val;
          rs_fwd[p]                   = 1'b1;
        end else begin
          stall_c = 1'b1;
        end
      end
    end
  end

  assign stall        = stall_c;
  assign issue_accept = issue_valid & advance & ~stall_c & ~flush;
  assign stall_count  = stall_count_q;

  always_comb begin
    live_d = live_q;
    rd_d   = rd_q;
    lat_d  = lat_q;
    if (advance) begin
      for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
        live_d[k] = live_q[k-1];
        rd_d[k]   = rd_q[k-1];
        lat_d[k]  = lat_q[k-1];
      end
      // x0 is never tracked; it always reads from the register file.
      live_d[0] = issue_accept && (issue_rd != '0);
      rd_d[0]   = issue_rd;
      lat_d[0]  = issue_lat;
    end
    if (flush) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        if (k < int'(FLUSH_DEPTH)) begin
          live_d[k] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_c && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live_q        <= '0;
      stall_count_q <= '0;
    end else begin
      live_q        <= live_d;
      stall_count_q <= stall_count_d;
    end
    rd_q  <= rd_d;
    lat_q <= lat_d;
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard with default parameters.
module tb_reg_scoreboard;

  localparam logic [31:0] SV0 = 32'hA0A0_0000;
  localparam logic [31:0] SV1 = 32'hB1B1_1111;
  localparam logic [31:0] SV2 = 32'hC2C2_2222;
  localparam logic [31:0] RF0 = 32'h1111_0000;
  localparam logic [31:0] RF1 = 32'h2222_0000;

  logic        clk;
  logic        rst;
  logic        advance;
  logic        flush;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [1:0]  issue_lat;
  logic [95:0] stage_value;
  logic [1:0]  rs_en;
  logic [9:0]  rs_addr;
  logic [63:0] rf_data;
  logic [63:0] rs_data;
  logic [1:0]  rs_fwd;
  logic        stall;
  logic        issue_accept;
  logic [15:0] stall_count;

  int total;
  int bad;

  reg_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .advance      (advance),
    .flush        (flush),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_lat    (issue_lat),
    .stage_value  (stage_value),
    .rs_en        (rs_en),
    .rs_addr      (rs_addr),
    .rf_data      (rf_data),
    .rs_data      (rs_data),
    .rs_fwd       (rs_fwd),
    .stall        (stall),
    .issue_accept (issue_accept),
    .stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [4:0] rd, input logic [1:0] lat);
    issue_valid = v;
    issue_rd    = rd;
    issue_lat   = lat;
  endtask

  task automatic rd_ports(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1);
    rs_en   = en;
    rs_addr = {a1, a0};
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    advance     = 1'b1;
    flush       = 1'b0;
    stage_value = {SV2, SV1, SV0};
    rf_data     = {RF1, RF0};
    issue(1'b0, 5'd0, 2'd0);
    rd_ports(2'b00, 5'd0, 5'd0);
    tick();
    tick();

    // During reset: empty-state outputs.
    rd_ports(2'b11, 5'd5, 5'd7);
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_fwd", rs_fwd, 2'b00);
    chk("rst_data", rs_data, {RF1, RF0});
    rst = 1'b0;
    rd_ports(2'b00, 5'd0, 5'd0);
    #1;
    chk("rst_count", stall_count, 16'd0);

    // ALU back-to-back forward.
    issue(1'b1, 5'd5, 2'd0);
    #1;
    chk("alu_accept", issue_accept, 1'b1);
    tick();
    issue(1'b0, 5'd0, 2'd0);
    rd_ports(2'b01, 5'd5, 5'd0);
    #1;
    chk("alu_fwd", rs_fwd, 2'b01);
    chk("alu_data", rs_data, {RF1, SV0});
    chk("alu_stall", stall, 1'b0);
    tick();

    // Load-use: one stall cycle, then forward from stage 1.
    rd_ports(2'b00, 5'd0, 5'd0);
    issue(1'b1, 5'd7, 2'd1);
    #1;
    chk("ld_accept", issue_accept, 1'b1);
    tick();
    issue(1'b1, 5'd9, 2'd0);
    rd_ports(2'b11, 5'd7, 5'd5);
    #1;
    chk("ld_stall", stall, 1'b1);
    chk("ld_fwd_stall", rs_fwd, 2'b10);
    chk("ld_refuse", issue_accept, 1'b0);
    chk("ld_p1_data", rs_data[63:32], SV2);
    tick();
    chk("ld_count1", stall_count, 16'd1);
    chk("ld_stall2", stall, 1'b0);
    chk("ld_fwd", rs_fwd, 2'b01);
    chk("ld_data", rs_data, {RF1, SV1});
    chk("ld_accept2", issue_accept, 1'b1);
    tick();
    chk("ld_count_hold", stall_count, 16'd1);

    // Priority: entries 0 and 2 both hold rd=3; x0 passthrough.
    rd_ports(2'b00, 5'd0, 5'd0);
    issue(1'b1, 5'd3, 2'd0);
    tick();
    issue(1'b0, 5'd0, 2'd0);
    tick();
    issue(1'b1, 5'd3, 2'd0);
    tick();
    issue(1'b1, 5'd0, 2'd0);
    rd_ports(2'b11, 5'd3, 5'd0);
    #1;
    chk("prio_data", rs_data, {RF1, SV0});
    chk("prio_fwd", rs_fwd, 2'b01);
    chk("x0_accept", issue_accept, 1'b1);
    tick();
    issue(1'b0, 5'd0, 2'd0);
    #1;
    chk("x0_data", rs_data, {RF1, SV1});
    chk("x0_fwd", rs_fwd, 2'b01);
    chk("x0_stall", stall, 1'b0);

    // Hold for three cycles, then flush with advance low.
    rd_ports(2'b00, 5'd0, 5'd0);
    issue(1'b1, 5'd12, 2'd0);
    tick();
    advance = 1'b0;
    issue(1'b1, 5'd14, 2'd0);
    rd_ports(2'b11, 5'd12, 5'd3);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_accept", issue_accept, 1'b0);
      chk("hold_data", rs_data, {SV2, SV0});
      chk("hold_fwd", rs_fwd, 2'b11);
      tick();
    end
    flush = 1'b1;
    #1;
    chk("flush_accept", issue_accept, 1'b0);
    tick();
    flush = 1'b0;
    issue(1'b0, 5'd0, 2'd0);
    #1;
    chk("flush_data", rs_data, {SV2, RF0});
    chk("flush_fwd", rs_fwd, 2'b10);

    // Build stall_count=9 and three live entries, then reset.
    advance = 1'b1;
    rd_ports(2'b00, 5'd0, 5'd0);
    issue(1'b1, 5'd20, 2'd3);
    tick();
    advance = 1'b0;
    issue(1'b0, 5'd0, 2'd0);
    rd_ports(2'b01, 5'd20, 5'd0);
    #1;
    chk("lat3_stall", stall, 1'b1);
    repeat (8) tick();
    chk("count9", stall_count, 16'd9);
    advance = 1'b1;
    rd_ports(2'b00, 5'd0, 5'd0);
    issue(1'b1, 5'd21, 2'd0);
    tick();
    issue(1'b1, 5'd22, 2'd0);
    tick();
    issue(1'b0, 5'd0, 2'd0);
    rd_ports(2'b11, 5'd22, 5'd20);
    #1;
    chk("pre_rst_stall_lat3_wb", stall, 1'b1);
    chk("pre_rst_count", stall_count, 16'd9);
    rst = 1'b1;
    issue(1'b1, 5'd23, 2'd0);
    #1;
    chk("mid_rst_stall", stall, 1'b0);
    chk("mid_rst_fwd", rs_fwd, 2'b00);
    chk("mid_rst_data", rs_data, {RF1, RF0});
    chk("mid_rst_accept", issue_accept, 1'b1);
    tick();
    rst = 1'b0;
    issue(1'b0, 5'd0, 2'd0);
    rd_ports(2'b11, 5'd22, 5'd21);
    #1;
    chk("post_rst_data", rs_data, {RF1, RF0});
    chk("post_rst_fwd", rs_fwd, 2'b00);
    chk("post_rst_count", stall_count, 16'd0);
    chk("post_rst_stall", stall, 1'b0);

    // Saturation of stall_count.
    rd_ports(2'b00, 5'd0, 5'd0);
    issue(1'b1, 5'd25, 2'd3);
    tick();
    advance = 1'b0;
    issue(1'b0, 5'd0, 2'd0);
    rd_ports(2'b01, 5'd25, 5'd0);
    repeat (65534) tick();
    chk("sat_fffe", stall_count, 16'hFFFE);
    repeat (6) tick();
    chk("sat_ffff", stall_count, 16'hFFFF);
    chk("sat_stall", stall, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 The block SHALL provide parameter ADDR_W, default 5, meaning register address width.
REQ-002 The block SHALL provide parameter DATA_W, default 32, meaning register data width.
REQ-003 The block SHALL provide parameter DEPTH, default 3, meaning the number of tracked in-flight stages; entry 0 is execute, entry DEPTH-1 is writeback.
REQ-004 The block SHALL provide parameter READ_PORTS, default 2, meaning the number of source-operand lookup ports.
REQ-005 The block SHALL provide parameter FLUSH_DEPTH, default 1, meaning the number of youngest entries killed by flush.
REQ-006 The block SHALL provide parameter LAT_W, default $clog2(DEPTH), minimum 1, meaning the latency field width.
REQ-007 The block SHALL use one clock; reset is synchronous and active-high.
REQ-008 Port clk, input, 1: the only clock, rising edge.
REQ-009 Port rst, input, 1: synchronous active-high reset.
REQ-010 Port advance, input, 1: the pipeline moves this cycle; 0 means a downstream hold.
REQ-011 Port flush, input, 1: kill the youngest FLUSH_DEPTH entries.
REQ-012 Port issue_valid, input, 1: decode presents an instruction.
REQ-013 Port issue_rd, input, ADDR_W: target register of the issued instruction.
REQ-014 Port issue_lat, input, LAT_W: first entry index at which the result exists (ALU 0, load 1).
REQ-015 Port stage_value, input, DEPTH*DATA_W: result value held by stage k, in slice k.
REQ-016 Port rs_en, input, READ_PORTS: lookup enable per port.
REQ-017 Port rs_addr, input, READ_PORTS*ADDR_W: source register per port.
REQ-018 Port rf_data, input, READ_PORTS*DATA_W: register-file read data per port.
REQ-019 Port rs_data, output, READ_PORTS*DATA_W: resolved operand per port.
REQ-020 Port rs_fwd, output, READ_PORTS: port p used a forwarded value.
REQ-021 Port stall, output, 1: an operand is pending; the issue is refused.
REQ-022 Port issue_accept, output, 1: the issue enters entry 0 at this edge.
REQ-023 Port stall_count, output, 16: saturating count of stall cycles.

Function
REQ-024 Each entry SHALL hold live, rd and lat fields; entry k is ready when live=1 and k>=lat.
REQ-025 For each port p with rs_en[p]=1 and rs_addr[p]!=0, the block SHALL select the lowest-index live entry with rd equal to rs_addr[p], so the youngest producer wins.
REQ-026 When that match is ready, rs_data[p] SHALL equal stage_value slice k and rs_fwd[p] SHALL be 1.
REQ-027 When that match is not ready, the block SHALL assert stall combinationally and set rs_fwd[p]=0.
REQ-028 With no match, rs_en[p]=0, or rs_addr[p]=0, rs_data[p] SHALL equal rf_data[p] and rs_fwd[p]=0.
REQ-029 The block SHALL compute issue_accept = issue_valid & advance & ~stall & ~flush.
REQ-030 On a clock edge with advance=1, entry k+1 SHALL take entry k for k<DEPTH-1, entry DEPTH-1 SHALL retire, and entry 0 SHALL take {issue_accept & (issue_rd!=0), issue_rd, issue_lat}; otherwise entry 0 is a bubble with live=0.
REQ-031 On a clock edge with advance=0, all entries SHALL hold.
REQ-032 Flush SHALL clear live on post-update entries 0..FLUSH_DEPTH-1 and SHALL take priority over the shift into those entries; flush with advance=0 SHALL still clear them.
REQ-033 An issue_lat value greater than DEPTH-1 SHALL be treated as never ready before retirement.
REQ-034 stall_count SHALL increment on each edge where stall=1 and SHALL saturate at 16'hFFFF.
REQ-035 Lookups SHALL be combinational with zero-cycle latency; entry state SHALL update one cycle after the edge.

Reset
REQ-036 On an edge with rst=1, all live bits SHALL be 0 and stall_count SHALL be 0.
REQ-037 During and after reset, outputs SHALL follow from empty state: stall=0, rs_fwd=0, rs_data=rf_data, and issue_accept per REQ-029.
REQ-038 Reset SHALL override advance, flush and issue in the same cycle.

Verification
REQ-039 ALU back-to-back: issue rd=5, lat=0; next cycle rs_addr[0]=5 -> rs_fwd[0]=1, rs_data[0]=stage_value[0], stall=0.
REQ-040 Load-use: issue rd=7, lat=1; next cycle read 7 -> stall=1 for one cycle, stall_count=1; the following cycle read 7 -> rs_fwd=1 from stage_value[1].
REQ-041 Priority and x0: entries 0 and 2 both have rd=3 -> slice 0 selected; a read of x0 with rd=0 issued -> rf_data passes through, stall=0.
REQ-042 Hold and flush: advance=0 for 3 cycles -> entries unchanged, issue_accept=0; flush=1 -> entry 0 cleared, so a read of its rd returns rf_data.
REQ-043 Reset mid-operation: 3 live entries plus stall_count=9, assert rst -> next cycle all lookups return rf_data, stall_count=0.
REQ-044 Saturation: force 65540 stall cycles -> stall_count=16'hFFFF.
